// File: rtl/systolic_sequencer.sv
// Sequencer for the systolic array datapath: loads weights, swaps them in, and streams input rows
// for each tile of a run. It prefetches the next tile's weights during a stream and drains the array at the end.
package Config;
  localparam int sys_rows = 4;
  localparam int sys_cols = 4;
  localparam int A_rows   = 8;
endpackage

module systolic_sequencer #(
  parameter int SYS_ROWS = Config::sys_rows,
  parameter int SYS_COLS = Config::sys_cols,
  parameter int A_ROWS   = Config::A_rows,
  parameter int PIPE_LAT = SYS_ROWS + SYS_COLS,
  parameter int TILE_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              w_done,
  input  logic              if_done,
  output logic              w_buffer_read,
  output logic              if_buffer_read,
  output logic              clr_w,
  output logic              clr_if,
  output logic              switch,
  output logic              of_valid,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD_W | first tile's weights loading, one word per cycle
  // WAIT_W | input rows finished before the prefetched weights did
  // SWITCH | preloaded weights become active
  // STREAM | input rows streaming; next tile's weights prefetching
  // DRAIN  | waiting for the last outputs to leave the array
  // FIN    | done pulse
  typedef enum logic [2:0] {
    IDLE, LOAD_W, WAIT_W, SWITCH, STREAM, DRAIN, FIN
  } state_t;

  state_t              state, state_nxt;
  logic [TILE_W-1:0]   tiles_left, tiles_left_nxt;
  logic                w_ready, w_ready_nxt;
  logic [PIPE_LAT-1:0] of_pipe;
  logic                prefetch;

  assign prefetch = (state == STREAM || state == WAIT_W) && (tiles_left != '0) && !w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tiles_left <= '0;
      w_ready    <= 1'b0;
      of_pipe    <= '0;
    end else begin
      state      <= state_nxt;
      tiles_left <= tiles_left_nxt;
      w_ready    <= w_ready_nxt;
      of_pipe    <= {of_pipe[PIPE_LAT-2:0], if_buffer_read};
    end
  end

  always_comb begin
    state_nxt      = state;
    tiles_left_nxt = tiles_left;
    w_ready_nxt    = w_ready;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_tiles != '0) begin
            tiles_left_nxt = num_tiles;
            state_nxt      = LOAD_W;
          end else begin
            state_nxt = FIN;
          end
        end
      end
      LOAD_W: if (w_done) state_nxt = SWITCH;
      SWITCH: begin
        tiles_left_nxt = tiles_left - TILE_W'(1);
        state_nxt      = STREAM;
      end
      STREAM: begin
        if (prefetch && w_done) w_ready_nxt = 1'b1;
        if (if_done) begin
          if (tiles_left == '0) begin
            state_nxt = DRAIN;
          end else if (w_ready || (prefetch && w_done)) begin
            // a prefetch finishing on the last input row counts as ready
            state_nxt   = SWITCH;
            w_ready_nxt = 1'b0;
          end else begin
            state_nxt = WAIT_W;
          end
        end
      end
      WAIT_W: if (w_done) state_nxt = SWITCH;
      DRAIN:  if (of_pipe[PIPE_LAT-2:0] == '0) state_nxt = FIN;
      FIN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign w_buffer_read  = (state == LOAD_W) || prefetch;
  assign if_buffer_read = (state == STREAM);
  assign clr_w          = !w_buffer_read;
  assign clr_if         = !if_buffer_read;
  assign switch         = (state == SWITCH);
  assign of_valid       = of_pipe[PIPE_LAT-1];
  assign busy           = (state != IDLE);
  assign done           = (state == FIN);

  // when a tile is at least as tall as the weight load, the prefetch always wins
  always @(posedge clk) begin
    if (rst && (A_ROWS >= SYS_ROWS)) assert (state != WAIT_W);
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer: two instances (tall and short tiles) against a
// schedule model that derives every strobe from tile count and array dimensions.
module tb_systolic_sequencer;
  localparam int S   = 4;
  localparam int P   = 8;
  localparam int A_A = 8;
  localparam int A_B = 2;

  typedef logic [7:0] vec_t;  // {w_rd, if_rd, switch, of_valid, busy, done, clr_w, clr_if}
  localparam vec_t IDLE_V = 8'b0000_0011;

  logic clk, rst;
  logic start_a, start_b;
  logic [7:0] num_a, num_b;
  logic w_done_a, if_done_a, w_done_b, if_done_b;
  logic wr_a, ir_a, clrw_a, clri_a, sw_a, ofv_a, busy_a, done_a;
  logic wr_b, ir_b, clrw_b, clri_b, sw_b, ofv_b, busy_b, done_b;
  int wcnt_a, icnt_a, wcnt_b, icnt_b;

  vec_t qa[$], qb[$];
  vec_t mon_ea, mon_eb, mon_oa, mon_ob;
  int checks, errors, pos_a, pos_b;

  systolic_sequencer #(.SYS_ROWS(S), .SYS_COLS(4), .A_ROWS(A_A), .PIPE_LAT(P), .TILE_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .num_tiles(num_a),
    .w_done(w_done_a), .if_done(if_done_a),
    .w_buffer_read(wr_a), .if_buffer_read(ir_a), .clr_w(clrw_a), .clr_if(clri_a),
    .switch(sw_a), .of_valid(ofv_a), .busy(busy_a), .done(done_a));

  systolic_sequencer #(.SYS_ROWS(S), .SYS_COLS(4), .A_ROWS(A_B), .PIPE_LAT(P), .TILE_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .num_tiles(num_b),
    .w_done(w_done_b), .if_done(if_done_b),
    .w_buffer_read(wr_b), .if_buffer_read(ir_b), .clr_w(clrw_b), .clr_if(clri_b),
    .switch(sw_b), .of_valid(ofv_b), .busy(busy_b), .done(done_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // datapath terminal counters: held at zero by clr, otherwise count and wrap
  always_ff @(posedge clk) begin
    wcnt_a <= clrw_a ? 0 : ((wcnt_a == S - 1)   ? 0 : wcnt_a + 1);
    icnt_a <= clri_a ? 0 : ((icnt_a == A_A - 1) ? 0 : icnt_a + 1);
    wcnt_b <= clrw_b ? 0 : ((wcnt_b == S - 1)   ? 0 : wcnt_b + 1);
    icnt_b <= clri_b ? 0 : ((icnt_b == A_B - 1) ? 0 : icnt_b + 1);
  end
  assign w_done_a  = (wcnt_a == S - 1);
  assign if_done_a = (icnt_a == A_A - 1);
  assign w_done_b  = (wcnt_b == S - 1);
  assign if_done_b = (icnt_b == A_B - 1);

  // Expected per-cycle trace of a run, cycle 1 being the first after start is sampled.
  function automatic void push_run(input int sel, input int n, output int len);
    bit wr[256], ir[256], swv[256];
    int a, t, last_rd, done_c;
    vec_t v;
    a = (sel == 0) ? A_A : A_B;
    for (int c = 0; c < 256; c++) begin
      wr[c] = 1'b0; ir[c] = 1'b0; swv[c] = 1'b0;
    end
    t = 0;
    last_rd = 0;
    done_c = 1;
    if (n != 0) begin
      for (int c = 1; c <= S; c++) wr[c] = 1'b1;
      t = S + 1;
      for (int i = 0; i < n; i++) begin
        swv[t] = 1'b1;
        for (int c = t + 1; c <= t + a; c++) ir[c] = 1'b1;
        last_rd = t + a;
        if (i < n - 1) begin
          for (int c = t + 1; c <= t + S; c++) wr[c] = 1'b1;
          t = t + ((a > S) ? a : S) + 1;
        end
      end
      done_c = last_rd + P + 1;
    end
    for (int c = 1; c <= done_c; c++) begin
      v = {wr[c], ir[c], swv[c], (c > P) ? ir[c - P] : 1'b0, 1'b1, (c == done_c), !wr[c], !ir[c]};
      if (sel == 0) qa.push_back(v);
      else qb.push_back(v);
    end
    if (sel == 0) pos_a = 0;
    else pos_b = 0;
    len = done_c;
  endfunction

  task automatic start_run(input int sel, input int n, output int len);
    @(posedge clk); #1;
    if (sel == 0) begin start_a = 1'b1; num_a = 8'(n); end
    else begin start_b = 1'b1; num_b = 8'(n); end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    push_run(sel, n, len);
  endtask

  // called at cycle 1 of a run; drives start during cycle k, which must be ignored
  task automatic pulse_start(input int sel, input int k, input logic [7:0] n);
    repeat (k - 1) @(posedge clk);
    #1;
    if (sel == 0) begin start_a = 1'b1; num_a = n; end
    else begin start_b = 1'b1; num_b = n; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_empty();
    int budget;
    budget = 0;
    while ((qa.size() != 0 || qb.size() != 0) && budget < 300) begin
      @(posedge clk);
      budget++;
    end
    checks++;
    if (budget >= 300) begin
      errors++;
      $display("FAIL run_timeout left_a=%0d left_b=%0d required=0", qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_oa = {wr_a, ir_a, sw_a, ofv_a, busy_a, done_a, clrw_a, clri_a};
      mon_ob = {wr_b, ir_b, sw_b, ofv_b, busy_b, done_b, clrw_b, clri_b};
      mon_ea = IDLE_V;
      mon_eb = IDLE_V;
      if (qa.size() != 0) begin mon_ea = qa.pop_front(); pos_a++; end
      if (qb.size() != 0) begin mon_eb = qb.pop_front(); pos_b++; end
      checks += 2;
      if (mon_oa !== mon_ea) begin
        errors++;
        $display("FAIL trace_a cycle=%0d t=%0t got=%b required=%b (wr ir sw ofv busy done clrw clri)",
                 pos_a, $time, mon_oa, mon_ea);
      end
      if (mon_ob !== mon_eb) begin
        errors++;
        $display("FAIL trace_b cycle=%0d t=%0t got=%b required=%b (wr ir sw ofv busy done clrw clri)",
                 pos_b, $time, mon_ob, mon_eb);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    checks = 0; errors = 0; pos_a = 0; pos_b = 0;
    rst = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    num_a = '0; num_b = '0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);

    start_run(0, 1, len); wait_empty();
    start_run(0, 2, len); wait_empty();
    start_run(1, 2, len); wait_empty();
    start_run(0, 0, len); wait_empty();
    start_run(0, 1, len); pulse_start(0, 8, 8'd3); wait_empty();

    start_run(0, 2, len);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    qb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    start_run(0, 1, len); wait_empty();

    for (int it = 0; it < 16; it++) begin
      int sel, n;
      sel = int'($urandom_range(0, 1));
      n   = int'($urandom_range(0, 4));
      start_run(sel, n, len);
      if (len > 2 && $urandom_range(0, 1) == 1)
        pulse_start(sel, int'($urandom_range(1, len - 1)), 8'($urandom_range(0, 255)));
      wait_empty();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Control FSM that drives the CNN accelerator datapath's buffer-read, counter-clear and weight-switch strobes so a run of weight tiles streams through the systolic array. Per tile it preloads weights, swaps them active with `switch`, and streams input-feature rows. It prefetches the next tile's weights during the current stream and drains the array after the last tile. It sits between the top-level command interface and the datapath, consuming the datapath's `w_done`/`if_done` terminal-count flags.

## Interface
- `SYS_ROWS`, default `Config::sys_rows`: array rows; length of one weight load in cycles.
- `SYS_COLS`, default `Config::sys_cols`: array columns.
- `A_ROWS`, default `Config::A_rows`: input rows streamed per tile.
- `PIPE_LAT`, default `SYS_ROWS+SYS_COLS`: cycles from an input read to the matching output column word on `of_data`.
- `TILE_W`, default 8: width of the tile count.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a run; sampled only in IDLE.
- `num_tiles`, in, `TILE_W`: tiles in the run; captured on accepted `start`.
- `w_done`, in, 1: datapath weight counter at `SYS_ROWS-1`.
- `if_done`, in, 1: datapath input counter at `A_ROWS-1`.
- `w_buffer_read`, out, 1: pop one weight word per cycle.
- `if_buffer_read`, out, 1: pop one input row per cycle.
- `clr_w`, out, 1: hold the datapath weight counter at 0.
- `clr_if`, out, 1: hold the datapath input counter at 0.
- `switch`, out, 1: one-cycle pulse that swaps preloaded weights into the active set.
- `of_valid`, out, 1: `of_data` holds a valid output word this cycle.
- `busy`, out, 1: run in progress.
- `done`, out, 1: one-cycle pulse at run end.

## Operation
- States: IDLE, LOAD_W, WAIT_W, SWITCH, STREAM, DRAIN, FIN.
- IDLE:
  - `start`=1 with `num_tiles`≠0: load `tiles_left`←`num_tiles` and go to LOAD_W.
  - `start`=1 with `num_tiles`=0: go to FIN.
  - `start` is ignored in all other states.
- LOAD_W:
  - `w_buffer_read`=1, `clr_w`=0.
  - On `w_done`=1, go to SWITCH. LOAD_W lasts exactly `SYS_ROWS` cycles.
- SWITCH:
  - `switch`=1 for exactly one cycle; `clr_w`=`clr_if`=1.
  - Decrement `tiles_left`, then go to STREAM.
- STREAM:
  - `if_buffer_read`=1, `clr_if`=0; on `if_done`, leave STREAM.
  - Prefetch: if `tiles_left`≠0, a weight-prefetch sub-sequence runs from the first STREAM cycle. It holds `w_buffer_read`=1 and `clr_w`=0 until `w_done`, then sets `w_ready` and holds `clr_w`=1.
  - On `if_done`:
    - `tiles_left`=0: go to DRAIN.
    - `w_ready`=1: go to SWITCH and clear `w_ready`.
    - Otherwise: go to WAIT_W.
- WAIT_W: prefetch continues; on `w_done`, go to SWITCH. This state occurs only when `A_ROWS`<`SYS_ROWS`.
- DRAIN:
  - `of_valid` is `if_buffer_read` delayed by `PIPE_LAT` cycles through a shift register.
  - Stay in DRAIN until the shift register is all zero, then go to FIN.
- FIN: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `w_buffer_read` and `if_buffer_read` are never asserted outside LOAD_W, WAIT_W and STREAM.
- `clr_w` and `clr_if` default to 1 whenever the matching read is not active.
- Reset (`rst`=0), at any time including mid-run:
  - State goes to IDLE; counters, `w_ready` and the shift register clear.
  - Output values: `clr_w`=`clr_if`=1; every other output 0.
  - An in-flight tile is abandoned; no `done` is produced.

## Timing
- All outputs are registered-state decodes; no combinational path from `start` to outputs.
- `start` sampled at edge 0 gives a first `w_buffer_read` cycle of 1.
- Per tile: `switch` is followed the next cycle by the first `if_buffer_read`.
- Back-to-back tiles with `A_ROWS`≥`SYS_ROWS`:
  - Exactly one SWITCH cycle separates the last input read of tile k from the first of tile k+1.
  - No bubble is caused by the weight load.
- `done` comes 1 cycle after the last `of_valid`.
- Total cycles from `start` to `done` with `A_ROWS`≥`SYS_ROWS`: 1 + `SYS_ROWS` + N·(`A_ROWS`+1) + `PIPE_LAT`.

## Test plan
- Reset values, parameters `SYS_ROWS`=4, `A_ROWS`=8, `PIPE_LAT`=8: hold `rst`=0 → `clr_w`=`clr_if`=1, all else 0; release, no `start` → outputs unchanged for 20 cycles.
- Single tile (same parameters), `start`@0 with `num_tiles`=1:
  - `w_buffer_read` cycles 1–4; `switch`@5; `if_buffer_read` 6–13.
  - `of_valid` 14–21; `done`@22; `busy` 1–22.
- Two tiles (same parameters), `num_tiles`=2:
  - Prefetch `w_buffer_read` 6–9 during STREAM 6–13; `switch`@5 and @14.
  - Second stream 15–22; `done`@31.
- WAIT_W path, `A_ROWS`=2, `SYS_ROWS`=4, `num_tiles`=2:
  - Stream 6–7; prefetch 6–9; WAIT_W 8–9; `switch`@10; stream 11–12.
- Zero tiles and ignored start: `num_tiles`=0 → `done`@1, no read strobes; `start` pulsed during STREAM → no effect on the sequence.
- Mid-run reset: assert `rst`=0 during cycle 8 of the two-tile run → outputs go to reset values immediately, no `done`; a new `start` then runs a clean single tile.
